rv32_wb_arbiter: RTL and testbench

RV32_WB_ARBITER -- requirements
Module: rv32_wb_arbiter

---
 rtl/rv32_pkg.sv | 6 +
 rtl/rv32_scoreboard.sv | 40 ++++
 rtl/rv32_wb_arbiter.sv | 71 +++++++
 tb/tb_rv32_wb_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared widths and arbitration-port enum for the writeback arbiter.
package rv32_pkg;
  localparam int REG_W = 5;
  localparam int DATA_W = 32;
  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;
endpackage

// File: rtl/rv32_scoreboard.sv
// rv32_scoreboard: long-latency pending vector with set/clear and issue hazard detection.
module rv32_scoreboard
  import rv32_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             issue_valid_i,
  input  logic             issue_long_i,
  input  logic [REG_W-1:0] rs1_i,
  input  logic [REG_W-1:0] rs2_i,
  input  logic [REG_W-1:0] rd_i,
  input  logic             clr_i,
  input  logic [REG_W-1:0] clr_rd_i,
  input  logic             wb_i,
  input  logic [REG_W-1:0] wb_rd_i,
  output logic             stall_o,
  output logic             busy_o
);
  logic [31:0] pending_q, pending_d, set_mask, clr_mask;
  logic busy_q, fwd_hit, set_en;
  always_comb begin
    // the register file reads synchronously, so a write leaving this cycle is not yet visible
    fwd_hit = wb_i && wb_rd_i != '0 && (wb_rd_i == rs1_i || wb_rd_i == rs2_i);
    stall_o = issue_valid_i && (pending_q[rs1_i] || pending_q[rs2_i] || pending_q[rd_i] || fwd_hit);
    set_en = issue_valid_i && !stall_o && issue_long_i && rd_i != '0;
    set_mask = set_en ? 32'd1 << rd_i : '0;
    clr_mask = clr_i ? 32'd1 << clr_rd_i : '0;
    pending_d = ((pending_q & ~clr_mask) | set_mask) & ~32'd1;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      busy_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      busy_q <= |pending_d;
    end
  end
  assign busy_o = busy_q;
endmodule

// File: rtl/rv32_wb_arbiter.sv
// rv32_wb_arbiter: round-robin writeback arbiter between the pipeline and a long-latency unit,
// with a registered register-file write port and issue scoreboard.
module rv32_wb_arbiter
  import rv32_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_valid_in,
  input  logic [REG_W-1:0]  a_rd_in,
  input  logic [DATA_W-1:0] a_value_in,
  output logic              a_ready_out,
  input  logic              b_valid_in,
  input  logic [REG_W-1:0]  b_rd_in,
  input  logic [DATA_W-1:0] b_value_in,
  output logic              b_ready_out,
  input  logic              issue_valid_in,
  input  logic              issue_long_in,
  input  logic [REG_W-1:0]  issue_rs1_in,
  input  logic [REG_W-1:0]  issue_rs2_in,
  input  logic [REG_W-1:0]  issue_rd_in,
  output logic              stall_out,
  output logic [REG_W-1:0]  rd_out,
  output logic              rd_writeback_out,
  output logic [DATA_W-1:0] rd_value_out,
  output logic              busy_out
);
  port_e prio_q, prio_d;
  logic [REG_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] value_q, value_d;
  logic wb_q, wb_d;
  always_comb begin
    a_ready_out = a_valid_in && (!b_valid_in || prio_q == PORT_A);
    b_ready_out = b_valid_in && !a_ready_out;
    // prio_q names the port that wins the next contended cycle
    prio_d = (a_valid_in && b_valid_in) ? (a_ready_out ? PORT_B : PORT_A) : prio_q;
    rd_d = a_ready_out ? a_rd_in : b_ready_out ? b_rd_in : rd_q;
    value_d = a_ready_out ? a_value_in : b_ready_out ? b_value_in : value_q;
    wb_d = (a_ready_out || b_ready_out) && rd_d != '0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_q <= PORT_A;
      rd_q <= '0;
      value_q <= '0;
      wb_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
      rd_q <= rd_d;
      value_q <= value_d;
      wb_q <= wb_d;
    end
  end
  rv32_scoreboard u_scoreboard (
    .clk          (clk),
    .reset_n      (reset_n),
    .issue_valid_i(issue_valid_in),
    .issue_long_i (issue_long_in),
    .rs1_i        (issue_rs1_in),
    .rs2_i        (issue_rs2_in),
    .rd_i         (issue_rd_in),
    .clr_i        (b_ready_out),
    .clr_rd_i     (b_rd_in),
    .wb_i         (wb_q),
    .wb_rd_i      (rd_q),
    .stall_o      (stall_out),
    .busy_o       (busy_out)
  );
  assign rd_out = rd_q;
  assign rd_value_out = value_q;
  assign rd_writeback_out = wb_q;
endmodule

// File: tb/tb_rv32_wb_arbiter.sv
// tb_rv32_wb_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_rv32_wb_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic a_valid_in, b_valid_in, a_ready_out, b_ready_out;
  logic [4:0] a_rd_in, b_rd_in, issue_rs1_in, issue_rs2_in, issue_rd_in, rd_out;
  logic [31:0] a_value_in, b_value_in, rd_value_out;
  logic issue_valid_in, issue_long_in, stall_out, rd_writeback_out, busy_out;
  int vectors = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv32_wb_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .a_valid_in(a_valid_in), .a_rd_in(a_rd_in), .a_value_in(a_value_in), .a_ready_out(a_ready_out),
    .b_valid_in(b_valid_in), .b_rd_in(b_rd_in), .b_value_in(b_value_in), .b_ready_out(b_ready_out),
    .issue_valid_in(issue_valid_in), .issue_long_in(issue_long_in),
    .issue_rs1_in(issue_rs1_in), .issue_rs2_in(issue_rs2_in), .issue_rd_in(issue_rd_in),
    .stall_out(stall_out), .rd_out(rd_out), .rd_writeback_out(rd_writeback_out),
    .rd_value_out(rd_value_out), .busy_out(busy_out)
  );

  task automatic idle();
    a_valid_in = 0; a_rd_in = 0; a_value_in = 0;
    b_valid_in = 0; b_rd_in = 0; b_value_in = 0;
    issue_valid_in = 0; issue_long_in = 0;
    issue_rs1_in = 0; issue_rs2_in = 0; issue_rd_in = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    #1 reset_n = 0;
    #1;
    vectors++; if (rd_writeback_out !== 1'b0) begin errors++; $display("FAIL reset_wb got %b want 0", rd_writeback_out); end
    vectors++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_out); end
    vectors++; if (rd_out !== 5'd0 || rd_value_out !== 32'd0) begin errors++; $display("FAIL reset_port got rd=%0d val=%h want 0/0", rd_out, rd_value_out); end
    tick(); tick();
    reset_n = 1;
    mid();
    vectors++; if (a_ready_out !== 1'b0 || b_ready_out !== 1'b0) begin errors++; $display("FAIL reset_ready got %b%b want 00", a_ready_out, b_ready_out); end
    tick();
  endtask

  task automatic test_single_a();
    idle();
    a_valid_in = 1; a_rd_in = 5; a_value_in = 32'h12345678;
    mid();
    vectors++; if (a_ready_out !== 1'b1 || b_ready_out !== 1'b0) begin errors++; $display("FAIL single_a_ready got %b%b want 10", a_ready_out, b_ready_out); end
    tick();
    idle();
    mid();
    vectors++; if (rd_out !== 5'd5 || rd_value_out !== 32'h12345678 || rd_writeback_out !== 1'b1)
      begin errors++; $display("FAIL single_a_write got rd=%0d val=%h wb=%b want 5/12345678/1", rd_out, rd_value_out, rd_writeback_out); end
    tick();
    mid();
    vectors++; if (rd_writeback_out !== 1'b0 || rd_out !== 5'd5) begin errors++; $display("FAIL single_a_hold got wb=%b rd=%0d want 0/5", rd_writeback_out, rd_out); end
  endtask

  task automatic test_round_robin();
    tick();
    for (int i = 0; i < 4; i++) begin
      idle();
      a_valid_in = 1; a_rd_in = 5'(10 + i); a_value_in = 32'(100 + i);
      b_valid_in = 1; b_rd_in = 5'(20 + i); b_value_in = 32'(200 + i);
      mid();
      vectors++; if (a_ready_out !== (i % 2 == 0) || b_ready_out !== (i % 2 == 1))
        begin errors++; $display("FAIL rr_grant%0d got %b%b want %b%b", i, a_ready_out, b_ready_out, i % 2 == 0, i % 2 == 1); end
      if (i > 0) begin
        vectors++; if (rd_out !== ((i % 2 == 1) ? 5'(9 + i) : 5'(19 + i)))
          begin errors++; $display("FAIL rr_rd%0d got %0d want %0d", i, rd_out, (i % 2 == 1) ? 9 + i : 19 + i); end
      end
      tick();
    end
    idle();
    mid();
    vectors++; if (rd_out !== 5'd23 || rd_value_out !== 32'd203 || rd_writeback_out !== 1'b1)
      begin errors++; $display("FAIL rr_last got rd=%0d val=%0d wb=%b want 23/203/1", rd_out, rd_value_out, rd_writeback_out); end
    tick();
  endtask

  task automatic test_long_stall();
    idle(); tick();
    issue_valid_in = 1; issue_long_in = 1; issue_rd_in = 7; issue_rs1_in = 1; issue_rs2_in = 2;
    mid();
    vectors++; if (stall_out !== 1'b0) begin errors++; $display("FAIL long_issue_stall got %b want 0", stall_out); end
    tick();
    issue_long_in = 0; issue_rd_in = 8; issue_rs1_in = 7; issue_rs2_in = 0;
    for (int i = 0; i < 3; i++) begin
      mid();
      vectors++; if (stall_out !== 1'b1 || busy_out !== 1'b1) begin errors++; $display("FAIL long_wait%0d got stall=%b busy=%b want 1/1", i, stall_out, busy_out); end
      tick();
    end
    b_valid_in = 1; b_rd_in = 7; b_value_in = 32'h77;
    mid();
    vectors++; if (b_ready_out !== 1'b1 || stall_out !== 1'b1) begin errors++; $display("FAIL long_clear_cycle got bready=%b stall=%b want 1/1", b_ready_out, stall_out); end
    tick();
    b_valid_in = 0;
    mid();
    vectors++; if (busy_out !== 1'b0 || stall_out !== 1'b1 || rd_out !== 5'd7 || rd_writeback_out !== 1'b1)
      begin errors++; $display("FAIL long_inflight got busy=%b stall=%b rd=%0d wb=%b want 0/1/7/1", busy_out, stall_out, rd_out, rd_writeback_out); end
    tick();
    mid();
    vectors++; if (stall_out !== 1'b0) begin errors++; $display("FAIL long_release got %b want 0", stall_out); end
    tick();
    idle();
  endtask

  task automatic test_inflight_stall();
    idle(); tick();
    a_valid_in = 1; a_rd_in = 3; a_value_in = 32'h33;
    mid();
    vectors++; if (a_ready_out !== 1'b1) begin errors++; $display("FAIL inflight_grant got %b want 1", a_ready_out); end
    tick();
    a_valid_in = 0; issue_valid_in = 1; issue_rs1_in = 0; issue_rs2_in = 3; issue_rd_in = 4;
    mid();
    vectors++; if (stall_out !== 1'b1) begin errors++; $display("FAIL inflight_stall got %b want 1", stall_out); end
    tick();
    mid();
    vectors++; if (stall_out !== 1'b0) begin errors++; $display("FAIL inflight_release got %b want 0", stall_out); end
    tick();
    idle();
  endtask

  task automatic test_rd_zero();
    idle(); tick();
    issue_valid_in = 1; issue_long_in = 1; issue_rd_in = 9;
    mid();
    vectors++; if (stall_out !== 1'b0) begin errors++; $display("FAIL rd0_setup_stall got %b want 0", stall_out); end
    tick();
    idle();
    b_valid_in = 1; b_rd_in = 0; b_value_in = 32'hdead;
    mid();
    vectors++; if (b_ready_out !== 1'b1) begin errors++; $display("FAIL rd0_ready got %b want 1", b_ready_out); end
    tick();
    idle();
    issue_valid_in = 1; issue_rs1_in = 9; issue_rd_in = 10;
    mid();
    vectors++; if (rd_writeback_out !== 1'b0 || busy_out !== 1'b1 || stall_out !== 1'b1)
      begin errors++; $display("FAIL rd0_effect got wb=%b busy=%b stall=%b want 0/1/1", rd_writeback_out, busy_out, stall_out); end
    tick();
    idle();
    b_valid_in = 1; b_rd_in = 9;
    tick();
    idle();
    tick();
    mid();
    vectors++; if (busy_out !== 1'b0) begin errors++; $display("FAIL rd0_cleanup_busy got %b want 0", busy_out); end
    tick();
  endtask

  task automatic test_random();
    bit pend[32];
    int last_win;
    logic [4:0] erd;
    logic [31:0] eval_q;
    logic ewb, ea, eb, est, ebusy;
    idle();
    reset_n = 0;
    tick();
    reset_n = 1;
    foreach (pend[k]) pend[k] = 0;
    last_win = 1; erd = 0; eval_q = 0; ewb = 0;
    for (int n = 0; n < 400; n++) begin
      a_valid_in = 1'($urandom_range(0, 1));
      a_rd_in = 5'($urandom_range(0, 7)); a_value_in = $urandom;
      b_valid_in = ($urandom_range(0, 2) == 0);
      b_rd_in = 5'($urandom_range(0, 7)); b_value_in = $urandom;
      issue_valid_in = 1'($urandom_range(0, 1)); issue_long_in = 1'($urandom_range(0, 1));
      issue_rs1_in = 5'($urandom_range(0, 7)); issue_rs2_in = 5'($urandom_range(0, 7));
      issue_rd_in = 5'($urandom_range(0, 7));
      if (a_valid_in && b_valid_in) begin ea = (last_win == 1); eb = !ea; end
      else begin ea = a_valid_in; eb = b_valid_in; end
      est = issue_valid_in && (pend[issue_rs1_in] || pend[issue_rs2_in] || pend[issue_rd_in] ||
            (ewb && erd != 0 && (erd == issue_rs1_in || erd == issue_rs2_in)));
      ebusy = 0;
      foreach (pend[k]) ebusy |= pend[k];
      mid();
      vectors++; if (a_ready_out !== ea || b_ready_out !== eb) begin errors++; $display("FAIL rand_ready c%0d got %b%b want %b%b", n, a_ready_out, b_ready_out, ea, eb); end
      vectors++; if (stall_out !== est) begin errors++; $display("FAIL rand_stall c%0d got %b want %b", n, stall_out, est); end
      vectors++; if (rd_writeback_out !== ewb || rd_out !== erd || rd_value_out !== eval_q)
        begin errors++; $display("FAIL rand_port c%0d got wb=%b rd=%0d val=%h want %b/%0d/%h", n, rd_writeback_out, rd_out, rd_value_out, ewb, erd, eval_q); end
      vectors++; if (busy_out !== ebusy) begin errors++; $display("FAIL rand_busy c%0d got %b want %b", n, busy_out, ebusy); end
      if (a_valid_in && b_valid_in) last_win = ea ? 0 : 1;
      if (ea || eb) begin
        erd = ea ? a_rd_in : b_rd_in;
        eval_q = ea ? a_value_in : b_value_in;
        ewb = (erd != 0);
      end else ewb = 0;
      if (eb) pend[b_rd_in] = 0;
      if (issue_valid_in && !est && issue_long_in && issue_rd_in != 0) pend[issue_rd_in] = 1;
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    idle(); tick();
    issue_valid_in = 1; issue_long_in = 1; issue_rd_in = 9;
    tick();
    idle();
    a_valid_in = 1; a_rd_in = 12; a_value_in = 32'habc;
    mid();
    vectors++; if (a_ready_out !== 1'b1 || busy_out !== 1'b1) begin errors++; $display("FAIL rstmid_pre got ready=%b busy=%b want 1/1", a_ready_out, busy_out); end
    #1 reset_n = 0;
    #1;
    vectors++; if (rd_writeback_out !== 1'b0 || busy_out !== 1'b0 || rd_out !== 5'd0 || rd_value_out !== 32'd0)
      begin errors++; $display("FAIL rstmid_async got wb=%b busy=%b rd=%0d val=%h want 0/0/0/0", rd_writeback_out, busy_out, rd_out, rd_value_out); end
    tick();
    idle();
    tick();
    reset_n = 1;
    issue_valid_in = 1; issue_rs1_in = 9; issue_rd_in = 11;
    mid();
    vectors++; if (rd_writeback_out !== 1'b0 || busy_out !== 1'b0 || stall_out !== 1'b0)
      begin errors++; $display("FAIL rstmid_release got wb=%b busy=%b stall=%b want 0/0/0", rd_writeback_out, busy_out, stall_out); end
    tick();
    idle();
    a_valid_in = 1; a_rd_in = 1; b_valid_in = 1; b_rd_in = 2;
    mid();
    vectors++; if (rd_writeback_out !== 1'b0 || a_ready_out !== 1'b1 || b_ready_out !== 1'b0)
      begin errors++; $display("FAIL rstmid_prio got wb=%b ready=%b%b want 0/10", rd_writeback_out, a_ready_out, b_ready_out); end
    tick();
    idle();
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_round_robin();
    test_long_stall();
    test_inflight_stall();
    test_rd_zero();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
